// File: rtl/fir_tap_loader.sv
// +----------------------------------------------------------------------------+
// | fir_tap_loader                                                             |
// | Double-buffered FIR coefficient loader: shadow bank fill, atomic commit.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module fir_tap_loader #(
    parameter int NTAPS = 10,
    parameter int WIDTH = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       abort,
    input  logic [WIDTH-1:0]           coef_in,
    input  logic                       coef_valid,
    output logic                       coef_ready,
    output logic [WIDTH-1:0]           taps [NTAPS],
    output logic                       loading,
    output logic [$clog2(NTAPS+1)-1:0] count,
    output logic                       done
);

    localparam int CW = $clog2(NTAPS + 1);

    localparam logic [1:0] c_idle   = 2'd0;
    localparam logic [1:0] c_load   = 2'd1;
    localparam logic [1:0] c_commit = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] shadow_q [NTAPS];
    logic [WIDTH-1:0] shadow_d [NTAPS];
    logic [WIDTH-1:0] taps_q   [NTAPS];
    logic [WIDTH-1:0] taps_d   [NTAPS];

    logic w_ready;
    logic w_xfer;
    logic w_last;

    // An abort in LOAD wins over a same-cycle transfer, so it never counts.
    assign w_xfer = coef_valid && w_ready && !abort;
    assign w_last = (count_q == CW'(NTAPS - 1));

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= c_idle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_idle: begin
                if (start && !abort) begin
                    state_d = c_load;
                end
            end
            c_load: begin
                if (abort) begin
                    state_d = c_idle;
                end else if (w_xfer && w_last) begin
                    state_d = c_commit;
                end
            end
            c_commit: begin
                state_d = c_idle;
            end
            default: begin
                state_d = c_idle;
            end
        endcase
    end

    // FSM outputs
    always_comb begin
        w_ready = 1'b0;
        loading = 1'b0;
        if (state_q == c_load) begin
            w_ready = 1'b1;
            loading = 1'b1;
        end
    end

    // Datapath next values
    always_comb begin
        count_d  = count_q;
        done_d   = 1'b0;
        shadow_d = shadow_q;
        taps_d   = taps_q;
        case (state_q)
            c_idle: begin
                if (start && !abort) begin
                    count_d = '0;
                end
            end
            c_load: begin
                if (abort) begin
                    count_d = '0;
                end else if (w_xfer) begin
                    for (int k = 0; k < NTAPS; k++) begin
                        if (count_q == CW'(k)) begin
                            shadow_d[k] = coef_in;
                        end
                    end
                    count_d = count_q + CW'(1);
                end
            end
            c_commit: begin
                taps_d = shadow_q;
                done_d = 1'b1;
            end
            default: begin
                count_d = '0;
            end
        endcase
    end

    // Datapath registers; reset leaves the active bank holding an index ramp.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
            done_q  <= 1'b0;
            for (int i = 0; i < NTAPS; i++) begin
                shadow_q[i] <= '0;
                taps_q[i]   <= WIDTH'(i);
            end
        end else begin
            count_q  <= count_d;
            done_q   <= done_d;
            shadow_q <= shadow_d;
            taps_q   <= taps_d;
        end
    end

    assign coef_ready = w_ready;
    assign count      = count_q;
    assign done       = done_q;
    assign taps       = taps_q;

endmodule

`default_nettype wire

// File: tb/tb_fir_tap_loader.sv
// +----------------------------------------------------------------------------+
// | tb_fir_tap_loader                                                          |
// | Directed self-checking bench for fir_tap_loader.                           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_fir_tap_loader;

    localparam int NTAPS = 10;
    localparam int WIDTH = 16;
    localparam int CW    = $clog2(NTAPS + 1);

    logic             clock = 1'b0;
    logic             reset;
    logic             start;
    logic             abort;
    logic [WIDTH-1:0] coef_in;
    logic             coef_valid;
    logic             coef_ready;
    logic [WIDTH-1:0] taps [NTAPS];
    logic             loading;
    logic [CW-1:0]    count;
    logic             done;

    int checks = 0;
    int errors = 0;

    fir_tap_loader #(.NTAPS(NTAPS), .WIDTH(WIDTH)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .coef_in    (coef_in),
        .coef_valid (coef_valid),
        .coef_ready (coef_ready),
        .taps       (taps),
        .loading    (loading),
        .count      (count),
        .done       (done)
    );

    always #5 clock = ~clock;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_taps(input string tag, input int base);
        for (int i = 0; i < NTAPS; i++) begin
            check_value(tag, 32'(taps[i]), 32'(base + i));
        end
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        coef_valid = 1'b0;
        coef_in    = '0;
        step();
        reset = 1'b0;
    endtask

    task automatic begin_load();
        start = 1'b1;
        step();
        start = 1'b0;
        check_value("load_entry_loading", 32'(loading), 32'd1);
        check_value("load_entry_ready", 32'(coef_ready), 32'd1);
        check_value("load_entry_count", 32'(count), 32'd0);
    endtask

    // Transfers words base+first .. base+first+num-1; stall toggles valid 1/0.
    task automatic load_words(input int base, input int first, input int num, input bit stall);
        int n     = first;
        int guard = 0;
        bit v     = 1'b1;
        while (n < first + num && guard < 200) begin
            coef_valid = stall ? v : 1'b1;
            coef_in    = WIDTH'(base + n);
            if (coef_valid && coef_ready) begin
                step();
                n++;
                check_value("xfer_count", 32'(count), 32'(n));
            end else begin
                step();
                check_value("stall_count", 32'(count), 32'(n));
            end
            v = !v;
            guard++;
        end
        coef_valid = 1'b0;
        if (guard >= 200) begin
            check_value("load_timeout", 32'(n), 32'(first + num));
        end
    endtask

    // Entered right after the final transfer edge (FSM in COMMIT).
    task automatic finish_commit(input int base, input int old_base, input bit abort_in_commit);
        check_value("commit_loading", 32'(loading), 32'd0);
        check_value("commit_ready", 32'(coef_ready), 32'd0);
        check_value("commit_count", 32'(count), 32'(NTAPS));
        check_value("commit_done_early", 32'(done), 32'd0);
        check_value("commit_taps_first_old", 32'(taps[0]), 32'(old_base));
        check_value("commit_taps_last_old", 32'(taps[NTAPS-1]), 32'(old_base + NTAPS - 1));
        abort = abort_in_commit;
        step();
        abort = 1'b0;
        check_value("done_pulse", 32'(done), 32'd1);
        check_value("post_commit_loading", 32'(loading), 32'd0);
        check_taps("taps_new", base);
        step();
        check_value("done_drop", 32'(done), 32'd0);
        check_taps("taps_hold", base);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: observed timeout, expected completion");
        $fatal(1);
    end

    initial begin
        do_reset();
        check_value("rst_loading", 32'(loading), 32'd0);
        check_value("rst_ready", 32'(coef_ready), 32'd0);
        check_value("rst_count", 32'(count), 32'd0);
        check_value("rst_done", 32'(done), 32'd0);
        check_taps("rst_ramp", 0);

        // Full load, no stalls; abort during COMMIT must be ignored
        begin_load();
        load_words(100, 0, NTAPS, 1'b0);
        finish_commit(100, 0, 1'b1);

        // Stalled load
        do_reset();
        begin_load();
        load_words(100, 0, NTAPS, 1'b1);
        finish_commit(100, 0, 1'b0);

        // Abort after five words
        do_reset();
        begin_load();
        load_words(300, 0, 5, 1'b0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_value("abort_loading", 32'(loading), 32'd0);
        check_value("abort_count", 32'(count), 32'd0);
        repeat (3) begin
            step();
            check_value("abort_no_done", 32'(done), 32'd0);
        end
        check_taps("abort_taps", 0);

        // Abort together with the final transfer
        do_reset();
        begin_load();
        load_words(300, 0, NTAPS - 1, 1'b0);
        coef_valid = 1'b1;
        coef_in    = WIDTH'(309);
        abort      = 1'b1;
        step();
        abort      = 1'b0;
        coef_valid = 1'b0;
        check_value("abort_last_loading", 32'(loading), 32'd0);
        check_value("abort_last_count", 32'(count), 32'd0);
        check_value("abort_last_done", 32'(done), 32'd0);
        step();
        check_value("abort_last_done2", 32'(done), 32'd0);
        check_taps("abort_last_taps", 0);

        // Reset mid-load, then a clean load
        begin_load();
        load_words(400, 0, 7, 1'b0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_value("midrst_count", 32'(count), 32'd0);
        check_value("midrst_loading", 32'(loading), 32'd0);
        check_taps("midrst_taps", 0);
        begin_load();
        load_words(200, 0, NTAPS, 1'b0);
        finish_commit(200, 0, 1'b0);

        // start+abort in IDLE, then lone abort in IDLE
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        check_value("start_abort_idle", 32'(loading), 32'd0);
        step();
        abort = 1'b0;
        check_value("abort_idle", 32'(loading), 32'd0);

        // start during LOAD must not restart the counter
        begin_load();
        load_words(500, 0, 3, 1'b0);
        start      = 1'b1;
        coef_valid = 1'b1;
        coef_in    = WIDTH'(503);
        step();
        start      = 1'b0;
        coef_valid = 1'b0;
        check_value("start_in_load_count", 32'(count), 32'd4);
        check_value("start_in_load_loading", 32'(loading), 32'd1);
        load_words(500, 4, NTAPS - 4, 1'b0);
        finish_commit(500, 200, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
